// File: rtl/i2s_codec_target_if.sv
// I2S codec target bus: serial link pins plus the parallel RX/TX word side.
//   i2s_rstn/sclk/lrclk/sdin : link inputs from the I2S master
//   i2s_sdout                : return serial data to the master
//   rx_data/rx_vld/rx_err    : received word, per-channel valid pulse, short-slot pulse
//   tx_data0/tx_data1/tx_ack : per-channel TX words and their load acknowledges
interface i2s_codec_target_if #(
  parameter int unsigned WIDTH = 24
);
  logic             i2s_rstn;
  logic             i2s_sclk;
  logic             i2s_lrclk;
  logic             i2s_sdin;
  logic             i2s_sdout;
  logic [WIDTH-1:0] rx_data;
  logic [1:0]       rx_vld;
  logic             rx_err;
  logic [WIDTH-1:0] tx_data0;
  logic [WIDTH-1:0] tx_data1;
  logic [1:0]       tx_ack;

  // Master side: drives the link and supplies TX words.
  modport master (
    output i2s_rstn, i2s_sclk, i2s_lrclk, i2s_sdin, tx_data0, tx_data1,
    input  i2s_sdout, rx_data, rx_vld, rx_err, tx_ack
  );

  // Codec target side.
  modport slave (
    input  i2s_rstn, i2s_sclk, i2s_lrclk, i2s_sdin, tx_data0, tx_data1,
    output i2s_sdout, rx_data, rx_vld, rx_err, tx_ack
  );
endinterface

// File: rtl/i2s_codec_target.sv
// I2S codec target: oversamples an externally clocked I2S link on clk,
// deserialises one word per channel slot and serialises return audio.
//   clk  : system clock, at least 8x sclk
//   rst  : asynchronous active-low reset
//   bus  : i2s_codec_target_if.slave (link pins, rx word/pulses, tx words/acks)
module i2s_codec_target #(
  parameter int unsigned WIDTH = 24
) (
  input  logic                clk,
  input  logic                rst,
  i2s_codec_target_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  typedef enum logic {ST_IDLE, ST_SLOT} state_t;

  state_t           r_state;
  logic [2:0]       r_sclk_s;
  logic [2:0]       r_lr_s;
  logic [2:0]       r_sd_s;
  logic [2:0]       r_rstn_s;
  logic             r_prev_lr;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic [1:0]       r_rx_vld;
  logic             r_rx_err;
  logic [1:0]       r_tx_ack;
  logic             r_sdout;

  logic             w_rise;
  logic             w_fall;
  logic             w_lr;
  logic             w_sd;
  logic             w_link_up;
  logic             w_room;
  logic             w_full_end;
  logic [WIDTH-1:0] w_rx_word;
  logic [WIDTH-1:0] w_tx_word;

  // Two synchroniser stages ([0],[1]) plus a history stage ([2]) per link input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sclk_s <= '0;
      r_lr_s   <= '0;
      r_sd_s   <= '0;
      r_rstn_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], bus.i2s_sclk};
      r_lr_s   <= {r_lr_s[1:0],   bus.i2s_lrclk};
      r_sd_s   <= {r_sd_s[1:0],   bus.i2s_sdin};
      r_rstn_s <= {r_rstn_s[1:0], bus.i2s_rstn};
    end
  end

  assign w_rise    = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_fall    = ~r_sclk_s[1] & r_sclk_s[2];
  assign w_lr      = r_lr_s[1];
  assign w_sd      = r_sd_s[1];
  assign w_link_up = r_rstn_s[1];
  assign w_room    = (r_bit_cnt < FULL);
  // Slot-end word includes the boundary bit when there is still room for it.
  assign w_rx_word = w_room ? {r_rx_shift[WIDTH-2:0], w_sd} : r_rx_shift;
  // Final count (stored bits plus boundary bit) reaches WIDTH.
  assign w_full_end = (r_bit_cnt >= (FULL - CW'(1)));
  assign w_tx_word = w_lr ? bus.tx_data1 : bus.tx_data0;

  // Slot FSM with RX deserialiser, TX serialiser and registered pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_prev_lr  <= 1'b0;
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_vld   <= '0;
      r_rx_err   <= 1'b0;
      r_tx_ack   <= '0;
      r_sdout    <= 1'b0;
    end else begin
      r_rx_vld <= '0;
      r_rx_err <= 1'b0;
      r_tx_ack <= '0;

      // Channel history keeps tracking even while idle or held in link reset.
      if (w_rise) begin
        r_prev_lr <= w_lr;
      end

      if (!w_link_up) begin
        r_state   <= ST_IDLE;
        r_sdout   <= 1'b0;
        r_bit_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_sdout <= 1'b0;
            // First channel change aligns us; the partial slot before it is dropped.
            if (w_rise && (w_lr != r_prev_lr)) begin
              r_tx_shift     <= w_tx_word;
              r_tx_ack[w_lr] <= 1'b1;
              r_bit_cnt      <= '0;
              r_state        <= ST_SLOT;
            end
          end
          ST_SLOT: begin
            if (w_rise) begin
              if (w_room) begin
                r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_sd};
              end
              if (w_lr != r_prev_lr) begin
                // Boundary rise: close the ending slot and start the next one.
                if (w_full_end) begin
                  r_rx_data           <= w_rx_word;
                  r_rx_vld[r_prev_lr] <= 1'b1;
                end else begin
                  r_rx_err <= 1'b1;
                end
                r_tx_shift     <= w_tx_word;
                r_tx_ack[w_lr] <= 1'b1;
                r_bit_cnt      <= '0;
              end else if (w_room) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
              end
            end else if (w_fall) begin
              r_sdout    <= r_tx_shift[WIDTH-1];
              r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.i2s_sdout = r_sdout;
  assign bus.rx_data   = r_rx_data;
  assign bus.rx_vld    = r_rx_vld;
  assign bus.rx_err    = r_rx_err;
  assign bus.tx_ack    = r_tx_ack;

endmodule
